// File: rtl/vector_lane_sequencer.sv
// Runs a LANES x LANE_W vector ALU operation through one shared scalar ALU,
// one lane per cycle, with valid/ready handshakes on the request and result sides.
module vector_lane_sequencer #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_a,
    input  logic [LANES*LANE_W-1:0] in_b,
    input  logic [2:0]              in_op,
    input  logic                    in_vectorial,
    output logic [LANE_W-1:0]       alu_a,
    output logic [LANE_W-1:0]       alu_b,
    output logic [2:0]              alu_ctrl,
    input  logic [LANE_W-1:0]       alu_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_result,
    output logic                    out_zero,
    output logic [LANES-1:0]        out_lane_zero
);
    localparam int VW = LANES * LANE_W;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [VW-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             vect_q, vect_d;
    logic [CW-1:0]    cnt_q, cnt_d, last_q, last_d;
    logic [LANES-1:0] lane_zero_q, lane_zero_d;
    logic             zero_q, zero_d;
    logic             accept_s, last_lane_s;

    assign accept_s    = (state_q == ST_IDLE) && in_valid;
    assign last_lane_s = (cnt_q == last_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)    state_d = ST_EXEC; else state_d = ST_IDLE;
            ST_EXEC: if (last_lane_s) state_d = ST_DONE; else state_d = ST_EXEC;
            ST_DONE: if (out_ready)   state_d = ST_IDLE; else state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and ALU-side outputs; the ALU sees zeros outside EXEC
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = {LANE_W{1'b0}};
        alu_b     = {LANE_W{1'b0}};
        alu_ctrl  = 3'b000;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_EXEC: begin
                alu_a    = a_q[int'(cnt_q)*LANE_W +: LANE_W];
                alu_b    = b_q[int'(cnt_q)*LANE_W +: LANE_W];
                alu_ctrl = op_q;
            end
            ST_DONE: out_valid = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath next-state: latch on accept, capture one lane per EXEC cycle
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        vect_d      = vect_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        result_d    = result_q;
        lane_zero_d = lane_zero_q;
        zero_d      = zero_q;
        if (accept_s) begin
            a_d         = in_a;
            b_d         = in_b;
            op_d        = in_op;
            vect_d      = in_vectorial;
            cnt_d       = {CW{1'b0}};
            last_d      = in_vectorial ? CW'(LANES - 1) : {CW{1'b0}};
            result_d    = {VW{1'b0}};
            lane_zero_d = {LANES{1'b0}};
            zero_d      = 1'b0;
        end else if (state_q == ST_EXEC) begin
            result_d[int'(cnt_q)*LANE_W +: LANE_W] = alu_result;
            lane_zero_d[cnt_q] = (alu_result == {LANE_W{1'b0}});
            if (last_lane_s) begin
                // unexecuted lanes read 0, so scalar mode must look at lane 0 only
                zero_d = vect_q ? (&lane_zero_d) : lane_zero_d[0];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= {VW{1'b0}};
            b_q         <= {VW{1'b0}};
            op_q        <= 3'b000;
            vect_q      <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            last_q      <= {CW{1'b0}};
            result_q    <= {VW{1'b0}};
            lane_zero_q <= {LANES{1'b0}};
            zero_q      <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            vect_q      <= vect_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            result_q    <= result_d;
            lane_zero_q <= lane_zero_d;
            zero_q      <= zero_d;
        end
    end

    assign out_result    = result_q;
    assign out_zero      = zero_q;
    assign out_lane_zero = lane_zero_q;

endmodule
